uart_tx_fifo: RTL

Buffered UART transmitter that drives the serial receive line of the MicroBlaze design's UART (`uart_rtl_rxd`) in simulation and on hardware. It complements the existing line printer that decodes the design's transmit line. It accepts bytes on a valid/ready interface into a small FIFO and serialises them as 8N1 frames at a fixed baud rate, LSB first, with optional even parity. Default settings match the design: 100 MHz clock, 230400 baud.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, constants and divisor helper.
// UART_TX_PARITY_EN adds the PARITY state to the transmitter FSM.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } uart_tx_state_t;

  function automatic int unsigned uart_div(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with byte FIFO.
// Define UART_TX_PARITY_EN for an even parity bit before stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 230400,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

  uart_tx_state_t state, state_n;

  logic [BW-1:0]             baud, baud_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [IW-1:0]             idx, idx_n;
  logic                      txd_n;
  logic                      bit_end;
  logic                      load;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic [UART_DATA_BITS-1:0] dout;
`ifdef UART_TX_PARITY_EN
  logic                      par, par_n;
`endif

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid),
    .pop     (pop),
    .din     (tx_data),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign tx_ready = !full;
  assign busy     = (state != TX_IDLE) || !empty;
  assign bit_end  = baud == BAUD_LAST;

  always_comb begin
    state_n = state;
    baud_n  = baud;
    shift_n = shift;
    idx_n   = idx;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      TX_IDLE: begin
        load = !empty;
      end
      TX_START: begin
        if (bit_end) begin
          baud_n  = '0;
          idx_n   = '0;
          state_n = TX_DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          idx_n   = idx + 1'b1;
          if (idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = TX_PARITY;
`else
            state_n = TX_STOP;
`endif
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = TX_STOP;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = TX_IDLE;
          load    = !empty;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase

    // Pop straight into START so back-to-back frames have no idle gap
    if (load) begin
      pop     = 1'b1;
      shift_n = dout;
      idx_n   = '0;
      baud_n  = '0;
      state_n = TX_START;
`ifdef UART_TX_PARITY_EN
      par_n   = ^dout;
`endif
    end
  end

  // Line level follows the next state so uart_txd is a clean register
  always_comb begin
    txd_n = 1'b1;
    unique case (state_n)
      TX_START:  txd_n = 1'b0;
      TX_DATA:   txd_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: txd_n = par_n;
`endif
      default:   txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      baud     <= '0;
      shift    <= '0;
      idx      <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      shift    <= shift_n;
      idx      <= idx_n;
      uart_txd <= txd_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par <= 1'b0;
    else          par <= par_n;
  end
`endif

endmodule
